// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits, optional even parity, stop bit.
// Define SHIFT_PISO_PARITY_EN to compile in the parity bit between the last data bit and the stop bit.
module shift_piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SHIFT_PISO_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

`ifdef SHIFT_PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  logic par_r;
  logic par_nxt_s;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             accept_s;
  logic             serial_nxt_s;
  logic             active_nxt_s;
  logic             done_nxt_s;
  logic             serial_r;
  logic             active_r;
  logic             done_r;

  assign load_ready   = (state_r == IDLE) || (state_r == STOP);
  assign accept_s     = load_valid && load_ready;
  assign serial_out   = serial_r;
  assign frame_active = active_r;
  assign done         = done_r;

  // Next-state logic; line outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_nxt_s  = state_r;
    shift_nxt_s  = shift_r;
    cnt_nxt_s    = cnt_r;
`ifdef SHIFT_PISO_PARITY_EN
    par_nxt_s    = par_r;
`endif
    serial_nxt_s = 1'b1;
    active_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;

    case (state_r)
      IDLE, STOP: begin
        if (accept_s) begin
          state_nxt_s = START;
          shift_nxt_s = data_in;
`ifdef SHIFT_PISO_PARITY_EN
          par_nxt_s   = even_parity(data_in);
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = DATA;
        cnt_nxt_s   = {CW{1'b0}};
      end
      DATA: begin
        if (cnt_r == LAST_BIT) begin
`ifdef SHIFT_PISO_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
          shift_nxt_s = advance(shift_r);
        end
      end
`ifdef SHIFT_PISO_PARITY_EN
      PARITY: begin
        state_nxt_s = STOP;
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    case (state_nxt_s)
      START: begin
        serial_nxt_s = 1'b0;
        active_nxt_s = 1'b1;
      end
      DATA: begin
        serial_nxt_s = head_bit(shift_nxt_s);
        active_nxt_s = 1'b1;
      end
`ifdef SHIFT_PISO_PARITY_EN
      PARITY: begin
        serial_nxt_s = par_nxt_s;
        active_nxt_s = 1'b1;
      end
`endif
      STOP: begin
        serial_nxt_s = 1'b1;
        active_nxt_s = 1'b1;
        done_nxt_s   = 1'b1;
      end
      default: begin
        serial_nxt_s = 1'b1;
        active_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      shift_r  <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
`ifdef SHIFT_PISO_PARITY_EN
      par_r    <= 1'b0;
`endif
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shift_r  <= shift_nxt_s;
      cnt_r    <= cnt_nxt_s;
`ifdef SHIFT_PISO_PARITY_EN
      par_r    <= par_nxt_s;
`endif
      serial_r <= serial_nxt_s;
      active_r <= active_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_shift_piso_tx.sv
// Directed bench for shift_piso_tx: one MSB-first and one LSB-first instance share the same stimulus.
module tb_shift_piso_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       ready_m, serial_m, active_m, done_m;
  logic       ready_l, serial_l, active_l, done_l;

  int tests_run;
  int tests_failed;

  shift_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .serial_out(serial_m), .frame_active(active_m), .done(done_m)
  );

  shift_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .serial_out(serial_l), .frame_active(active_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " serial_m"}, 32'(serial_m), 32'd1);
    check_eq({tag, " active_m"}, 32'(active_m), 32'd0);
    check_eq({tag, " ready_m"},  32'(ready_m),  32'd1);
    check_eq({tag, " done_m"},   32'(done_m),   32'd0);
    check_eq({tag, " serial_l"}, 32'(serial_l), 32'd1);
    check_eq({tag, " active_l"}, 32'(active_l), 32'd0);
    check_eq({tag, " done_l"},   32'(done_l),   32'd0);
  endtask

  // Called just after the accept edge; walks start, data, optional parity and ends sitting in the stop cycle.
  // em/el hold the expected data bits in line order (first bit sent in bit 7).
  // When bp is set, a new word bp_d is offered during data bit 2.
  task automatic frame_body(input string tag, input logic [7:0] em, input logic [7:0] el,
                            input logic ep, input bit bp, input logic [7:0] bp_d);
    check_eq({tag, " start_m"},  32'(serial_m), 32'd0);
    check_eq({tag, " start_l"},  32'(serial_l), 32'd0);
    check_eq({tag, " start_act"}, 32'(active_m), 32'd1);
    check_eq({tag, " start_rdy"}, 32'(ready_m), 32'd0);
    check_eq({tag, " start_done"}, 32'(done_m), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("%s bit%0d_m", tag, i), 32'(serial_m), 32'(em[7-i]));
      check_eq($sformatf("%s bit%0d_l", tag, i), 32'(serial_l), 32'(el[7-i]));
      check_eq($sformatf("%s bit%0d_rdy", tag, i), 32'(ready_m), 32'd0);
      check_eq($sformatf("%s bit%0d_done", tag, i), 32'(done_l), 32'd0);
      if (bp && i == 2) begin
        data_in    = bp_d;
        load_valid = 1'b1;
      end else begin
        data_in    = data_in;
      end
    end
`ifdef SHIFT_PISO_PARITY_EN
    tick();
    check_eq({tag, " parity_m"}, 32'(serial_m), 32'(ep));
    check_eq({tag, " parity_l"}, 32'(serial_l), 32'(ep));
    check_eq({tag, " parity_rdy"}, 32'(ready_m), 32'd0);
`endif
    tick();
    check_eq({tag, " stop_m"},    32'(serial_m), 32'd1);
    check_eq({tag, " stop_l"},    32'(serial_l), 32'd1);
    check_eq({tag, " stop_done"}, 32'(done_m),   32'd1);
    check_eq({tag, " stop_donel"}, 32'(done_l),  32'd1);
    check_eq({tag, " stop_rdy"},  32'(ready_m),  32'd1);
    check_eq({tag, " stop_act"},  32'(active_m), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    data_in      = 8'h00;
    load_valid   = 1'b1;
    tick();
    tick();
    check_idle("reset");
    rst        = 1'b0;
    load_valid = 1'b0;
    tick();
    check_idle("post_reset");

    // Basic frame A5: MSB-first line 0,1,0,1,0,0,1,0,1,1; LSB-first sends 1,0,1,0,0,1,0,1.
    data_in    = 8'hA5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 8'h00;
    frame_body("a5", 8'b10100101, 8'b10100101, 1'b0, 1'b0, 8'h00);
    tick();
    check_idle("a5_after");

    // 01: LSB-first sends the single 1 first.
    data_in    = 8'h01;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    frame_body("x01", 8'b00000001, 8'b10000000, 1'b1, 1'b0, 8'h00);
    tick();
    check_idle("x01_after");

    // A4 gives odd weight, so the parity bit is 1.
    data_in    = 8'hA4;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    frame_body("a4", 8'b10100100, 8'b00100101, 1'b1, 1'b0, 8'h00);
    tick();
    check_idle("a4_after");

    // Back-to-back FF then 00 with load_valid held throughout.
    data_in    = 8'hFF;
    load_valid = 1'b1;
    tick();
    data_in    = 8'h00;
    frame_body("b2b_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00);
    tick();
    load_valid = 1'b0;
    data_in    = 8'h77;
    frame_body("b2b_00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    check_idle("b2b_after");

    // Backpressure: C1 in flight, 3C offered during data, accepted only at stop.
    data_in    = 8'hC1;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    frame_body("bp_c1", 8'b11000001, 8'b10000011, 1'b1, 1'b1, 8'h3C);
    tick();
    load_valid = 1'b0;
    data_in    = 8'hFF;
    frame_body("bp_3c", 8'h3C, 8'h3C, 1'b0, 1'b0, 8'h00);
    tick();
    check_idle("bp_after");

    // Mid-frame reset during data bit 3 of 5A.
    data_in    = 8'h5A;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_eq("rst_start", 32'(serial_m), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check_eq("rst_bit3_m", 32'(serial_m), 32'd1);
    check_eq("rst_bit3_l", 32'(serial_l), 32'd1);
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'hA5;
    tick();
    check_idle("midrst");
    rst        = 1'b0;
    load_valid = 1'b0;
    tick();
    check_idle("midrst_idle");
    data_in    = 8'hC1;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    frame_body("post_rst", 8'b11000001, 8'b10000011, 1'b1, 1'b0, 8'h00);
    tick();
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
